// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: sequencing controller for the 4-bit up counter datapath.
//
// Holds an embedded WIDTH-bit count register (q) and a PW-bit prescaler (pc).
// It runs one-shot or periodic count sequences up to a terminal value that is
// latched at start. It emits a count-enable tick (ce_out) once every presc+1
// cycles. It also emits a one-cycle done pulse when the terminal count is
// reached.
//
// Ports:
//   clk     in   system clock, all state updates on the rising edge
//   clr     in   synchronous active-high reset, overrides every other input
//   start   in   begin a sequence (acted on in IDLE or DONE)
//   stop    in   abort the sequence and return to IDLE
//   pause   in   level; freezes an active sequence while high
//   mode    in   0 = one-shot, 1 = periodic (sampled live)
//   term    in   terminal count, latched at start
//   presc   in   prescale value, latched at start
//   ce_out  out  count-enable tick
//   q       out  current count
//   busy    out  high in RUN or HOLD
//   done    out  registered one-cycle pulse at terminal count
//   state   out  IDLE=00, RUN=01, HOLD=10, DONE=11

module counter_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PW    = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] term,
    input  logic [PW-1:0]    presc,
    output logic             ce_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10,
        StDone = 2'b11
    } state_e;

    state_e           st;
    logic [PW-1:0]    pc;
    logic [PW-1:0]    presc_l;
    logic [WIDTH-1:0] term_l;
    logic [WIDTH-1:0] q_next;

    assign state  = st;
    assign busy   = (st == StRun) || (st == StHold);
    assign ce_out = (st == StRun) && (pc == presc_l) && !pause && !stop;

    // WIDTH-bit increment; term_l is always reached before q could wrap.
    assign q_next = q + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (clr) begin
            st      <= StIdle;
            q       <= '0;
            pc      <= '0;
            term_l  <= '0;
            presc_l <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (st)
                StIdle: begin
                    q  <= '0;
                    pc <= '0;
                    // Priority stop > pause > start also applies to starting.
                    if (start && !stop && !pause) begin
                        term_l  <= term;
                        presc_l <= presc;
                        if (term == '0) begin
                            // Zero-length sequence completes immediately.
                            st   <= StDone;
                            done <= 1'b1;
                        end else begin
                            st <= StRun;
                        end
                    end
                end

                StRun: begin
                    if (stop) begin
                        st <= StIdle;
                        q  <= '0;
                        pc <= '0;
                    end else if (pause) begin
                        st <= StHold;
                    end else if (ce_out) begin
                        pc <= '0;
                        if (q_next == term_l) begin
                            done <= 1'b1;
                            if (mode) begin
                                q <= '0;
                            end else begin
                                q  <= term_l;
                                st <= StDone;
                            end
                        end else begin
                            q <= q_next;
                        end
                    end else begin
                        pc <= pc + PW'(1);
                    end
                end

                StHold: begin
                    // q and pc stay frozen so the tick phase is preserved.
                    if (stop) begin
                        st <= StIdle;
                        q  <= '0;
                        pc <= '0;
                    end else if (!pause) begin
                        st <= StRun;
                    end
                end

                StDone: begin
                    if (stop) begin
                        st <= StIdle;
                        q  <= '0;
                        pc <= '0;
                    end else if (start && !pause) begin
                        term_l  <= term;
                        presc_l <= presc;
                        q       <= '0;
                        pc      <= '0;
                        if (term == '0) begin
                            done <= 1'b1;
                        end else begin
                            st <= StRun;
                        end
                    end
                end

                default: st <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl. Inputs change on the falling edge and
// outputs are sampled on the falling edge after each rising edge.

module tb_counter_seq_ctrl;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_HOLD = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic       clk = 1'b0;
    logic       clr, start, stop, pause, mode;
    logic [3:0] term, presc;
    logic       ce_out, busy, done;
    logic [3:0] q;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    counter_seq_ctrl #(.WIDTH(4), .PW(4)) dut (
        .clk    (clk),
        .clr    (clr),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .mode   (mode),
        .term   (term),
        .presc  (presc),
        .ce_out (ce_out),
        .q      (q),
        .busy   (busy),
        .done   (done),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Pulse start for one rising edge; returns just after that edge (edge 0).
    task automatic do_start(input logic [3:0] t, input logic [3:0] p, input logic m);
        term  = t;
        presc = p;
        mode  = m;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int first_tick;

        clr = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        mode = 1'b0; term = '0; presc = '0;
        cyc();
        cyc();
        check("rst_state", int'(state), int'(S_IDLE));
        check("rst_q", int'(q), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_ce", int'(ce_out), 0);
        clr = 1'b0;

        // Reset mid-run at q=2, with start also high to show clr priority.
        do_start(4'd5, 4'd0, 1'b0);
        cyc();
        cyc();
        check("midrst_pre_q", int'(q), 2);
        clr   = 1'b1;
        start = 1'b1;
        cyc();
        check("midrst_q", int'(q), 0);
        check("midrst_state", int'(state), int'(S_IDLE));
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        cyc();
        check("midrst_state2", int'(state), int'(S_IDLE));
        clr   = 1'b0;
        start = 1'b0;

        // One-shot, term=5, presc=0.
        do_start(4'd5, 4'd0, 1'b0);
        check("os_run", int'(state), int'(S_RUN));
        check("os_q0", int'(q), 0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            check("os_q", int'(q), k);
            check("os_done", int'(done), (k == 5) ? 1 : 0);
        end
        check("os_state", int'(state), int'(S_DONE));
        check("os_busy", int'(busy), 0);
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("os_hold_q", int'(q), 5);
            check("os_hold_done", int'(done), 0);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("os_stop_state", int'(state), int'(S_IDLE));

        // Periodic, term=3, presc=1: tick every 2nd cycle, done every 6.
        do_start(4'd3, 4'd1, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            cyc();
            check("per_q", int'(q), (k / 2) % 3);
            check("per_done", int'(done), (k % 6 == 0) ? 1 : 0);
            check("per_ce", int'(ce_out), k % 2);
            check("per_busy", int'(busy), 1);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("per_stop_state", int'(state), int'(S_IDLE));

        // Pause: term=9, presc=2. Ticks at edges 3,6,9,12 -> q=4 after edge 12.
        // Pause is sampled high at edges 14..20 with pc=1. The resume edge 21
        // only returns to RUN, so the tick moves from edge 15 to edge 23 and
        // done moves from edge 27 to edge 35.
        do_start(4'd9, 4'd2, 1'b0);
        for (int k = 1; k <= 13; k++) cyc();
        check("pau_pre_q", int'(q), 4);
        pause = 1'b1;
        for (int k = 14; k <= 20; k++) begin
            cyc();
            check("pau_state", int'(state), int'(S_HOLD));
            check("pau_q", int'(q), 4);
            check("pau_ce", int'(ce_out), 0);
        end
        pause = 1'b0;
        lat = 20;
        first_tick = -1;
        while (!done && lat < 60) begin
            cyc();
            lat++;
            if (first_tick < 0 && q == 4'd5) first_tick = lat;
        end
        check("pau_first_tick", first_tick, 23);
        check("pau_done_edge", lat, 35);
        check("pau_done_q", int'(q), 9);
        check("pau_done_state", int'(state), int'(S_DONE));
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // start ignored in RUN; stop wins over start.
        do_start(4'd9, 4'd0, 1'b0);
        cyc();
        cyc();
        start = 1'b1;
        cyc();
        check("ign_q1", int'(q), 3);
        check("ign_state", int'(state), int'(S_RUN));
        cyc();
        check("ign_q2", int'(q), 4);
        stop = 1'b1;
        cyc();
        check("prec_state", int'(state), int'(S_IDLE));
        check("prec_q", int'(q), 0);
        stop  = 1'b0;
        start = 1'b0;
        cyc();
        check("prec_idle", int'(state), int'(S_IDLE));

        // term=0: straight to DONE with a done pulse.
        do_start(4'd0, 4'd0, 1'b0);
        check("z_state", int'(state), int'(S_DONE));
        check("z_done", int'(done), 1);
        check("z_q", int'(q), 0);
        check("z_busy", int'(busy), 0);
        cyc();
        check("z_done_clr", int'(done), 0);

        // start in DONE restarts immediately.
        do_start(4'd2, 4'd0, 1'b0);
        check("rs_state", int'(state), int'(S_RUN));
        check("rs_q", int'(q), 0);
        check("rs_done", int'(done), 0);
        cyc();
        check("rs_q1", int'(q), 1);
        cyc();
        check("rs_q2", int'(q), 2);
        check("rs_done2", int'(done), 1);
        check("rs_state2", int'(state), int'(S_DONE));
        stop = 1'b1;
        cyc();
        stop = 1'b0;

        // term=15, presc=0: full range, no wrap.
        do_start(4'd15, 4'd0, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            cyc();
            check("max_q", int'(q), k);
            check("max_done", int'(done), (k == 15) ? 1 : 0);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("max_hold_q", int'(q), 15);
            check("max_hold_state", int'(state), int'(S_DONE));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
